// File: rtl/picoMIPS_package.sv
// rtl/picoMIPS_package.sv - shared picoMIPS widths and PC sequencer state encoding
package picoMIPS_package;

  localparam int PMEM_WIDTH = 6;
  localparam int BOFF_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    HALT,
    FLUSH
  } seq_state_t;

endpackage

// File: rtl/pc_seq_target.sv
// rtl/pc_seq_target.sv - pc_target: branch target = pc_addr + sign-extended offset, modulo 2^AW
module pc_target
  import picoMIPS_package::*;
#(
  parameter int AW    = PMEM_WIDTH,
  parameter int OFF_W = BOFF_WIDTH
) (
  input  logic [AW-1:0]    pc_addr,
  input  logic [OFF_W-1:0] br_off,
  output logic [AW-1:0]    target
);

  logic [AW-1:0] off_ext;

  // Sized cast of a signed operand sign-extends; the add drops the carry so targets wrap both ways.
  assign off_ext = AW'($signed(br_off));
  assign target  = pc_addr + off_ext;

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - picoMIPS PC sequencer driving pcnt inc/ld; PC_SEQ_BRANCH_FLUSH_EN adds a post-branch FLUSH cycle
module pc_seq
  import picoMIPS_package::*;
#(
  parameter int AW    = PMEM_WIDTH,
  parameter int OFF_W = BOFF_WIDTH
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic [AW-1:0]    pc_addr,
  input  logic             is_branch,
  input  logic             br_cond,
  input  logic [OFF_W-1:0] br_off,
  input  logic             is_wait,
  input  logic             ext_valid,
  input  logic             is_halt,
  output logic             inc,
  output logic             ld,
  output logic [AW-1:0]    ld_addr,
  output logic             ext_ack,
  output logic             stalled,
  output logic             halted
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] target;

  pc_target #(.AW(AW), .OFF_W(OFF_W)) u_target (
    .pc_addr (pc_addr),
    .br_off  (br_off),
    .target  (target)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (is_halt) state_d = HALT;
        else if (is_branch) begin
`ifdef PC_SEQ_BRANCH_FLUSH_EN
          if (br_cond) state_d = FLUSH;
`endif
        end
        else if (is_wait && !ext_valid) state_d = WAIT;
      end
      WAIT:  if (ext_valid) state_d = RUN;
      HALT:  state_d = HALT;
      FLUSH: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are Mealy so pcnt acts on them at the very next edge.
  always_comb begin
    inc     = 1'b0;
    ld      = 1'b0;
    ld_addr = '0;
    ext_ack = 1'b0;
    stalled = (state_q == WAIT);
    halted  = (state_q == HALT);
    case (state_q)
      RUN: begin
        if (is_halt) begin
          inc = 1'b0;
        end else if (is_branch) begin
          if (br_cond) begin
            ld      = 1'b1;
            ld_addr = target;
          end else begin
            inc = 1'b1;
          end
        end else if (is_wait) begin
          ext_ack = ext_valid;
          inc     = ext_valid;
        end else begin
          inc = 1'b1;
        end
      end
      WAIT: begin
        ext_ack = ext_valid;
        inc     = ext_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq with a pcnt-like PC model
module tb_pc_seq;
  localparam int AW    = 6;
  localparam int OFF_W = 6;

  logic             clk;
  logic             nRst;
  logic             start;
  logic [AW-1:0]    pc;
  logic             is_branch;
  logic             br_cond;
  logic [OFF_W-1:0] br_off;
  logic             is_wait;
  logic             ext_valid;
  logic             is_halt;
  logic             inc;
  logic             ld;
  logic [AW-1:0]    ld_addr;
  logic             ext_ack;
  logic             stalled;
  logic             halted;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_seq #(.AW(AW), .OFF_W(OFF_W)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .start     (start),
    .pc_addr   (pc),
    .is_branch (is_branch),
    .br_cond   (br_cond),
    .br_off    (br_off),
    .is_wait   (is_wait),
    .ext_valid (ext_valid),
    .is_halt   (is_halt),
    .inc       (inc),
    .ld        (ld),
    .ld_addr   (ld_addr),
    .ext_ack   (ext_ack),
    .stalled   (stalled),
    .halted    (halted)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)    pc <= '0;
    else if (ld)  pc <= ld_addr;
    else if (inc) pc <= pc + 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode;
    is_branch = 0; br_cond = 0; br_off = '0;
    is_wait = 0; ext_valid = 0; is_halt = 0;
  endtask

  // Taken branch from current pc; in the flush build the following cycle must not move the PC.
  task automatic take_branch(input logic [OFF_W-1:0] off, input logic [AW-1:0] exp_tgt);
    is_branch = 1; br_cond = 1; br_off = off;
    #1;
    chk("br_ld", ld, 1);
    chk("br_inc", inc, 0);
    chk("br_ld_addr", ld_addr, exp_tgt);
    tick;
    chk("br_pc", pc, exp_tgt);
    clear_decode;
`ifdef PC_SEQ_BRANCH_FLUSH_EN
    is_halt = 1;
    #1;
    chk("flush_inc", inc, 0);
    chk("flush_ld", ld, 0);
    tick;
    chk("flush_pc", pc, exp_tgt);
    chk("flush_not_halted", halted, 0);
    is_halt = 0;
`endif
  endtask

  initial begin
    nRst = 1; start = 0;
    clear_decode;

    #15 nRst = 0;
    #1;
    chk("rst_inc", inc, 0);
    chk("rst_ld", ld, 0);
    chk("rst_ld_addr", ld_addr, 0);
    chk("rst_ack", ext_ack, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    #19 nRst = 1;
    #49;
    chk("idle_pc", pc, 0);
    chk("idle_inc", inc, 0);
    #1 start = 1;
    tick;
    chk("start_pc_hold", pc, 0);
    chk("run_inc", inc, 1);
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk("run_pc", pc, i);
    end

    take_branch(6'b111101, 6'd2);
    take_branch(6'd3, 6'd5);

    is_branch = 1; br_cond = 0; br_off = 6'b111101;
    #1;
    chk("nt_inc", inc, 1);
    chk("nt_ld", ld, 0);
    chk("nt_ld_addr", ld_addr, 0);
    tick;
    chk("nt_pc", pc, 6);
    clear_decode;

    take_branch(6'b111000, 6'd62);
    take_branch(6'd5, 6'd3);
    take_branch(6'b111100, 6'd63);
    tick;
    chk("inc_wrap_pc", pc, 0);
    take_branch(6'd10, 6'd10);

    is_wait = 1; ext_valid = 0;
    #1;
    chk("wait_inc", inc, 0);
    chk("wait_ack", ext_ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_stalled", stalled, 1);
      chk("wait_pc", pc, 10);
      chk("wait_ack_low", ext_ack, 0);
    end
    ext_valid = 1;
    #1;
    chk("wait_rel_ack", ext_ack, 1);
    chk("wait_rel_inc", inc, 1);
    tick;
    chk("wait_rel_pc", pc, 11);
    chk("wait_rel_stalled", stalled, 0);
    chk("fast_ack", ext_ack, 1);
    chk("fast_inc", inc, 1);
    tick;
    chk("fast_pc", pc, 12);
    chk("fast_stalled", stalled, 0);
    clear_decode;
    #1;
    chk("ack_pulse_end", ext_ack, 0);

    take_branch(6'd8, 6'd20);
    is_halt = 1; is_branch = 1; br_cond = 1; is_wait = 1; ext_valid = 1; br_off = 6'd4;
    #1;
    chk("prio_inc", inc, 0);
    chk("prio_ld", ld, 0);
    chk("prio_ack", ext_ack, 0);
    tick;
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 20);
    start = 0;
    tick;
    start = 1;
    tick;
    chk("halt_hold_pc", pc, 20);
    chk("halt_hold_flag", halted, 1);
    chk("halt_inc", inc, 0);
    chk("halt_ack", ext_ack, 0);
    nRst = 0;
    #1;
    chk("halt_rst_flag", halted, 0);
    chk("halt_rst_pc", pc, 0);
    nRst = 1;
    clear_decode;
    tick;
    chk("restart_pc", pc, 0);
    tick;
    chk("restart_pc1", pc, 1);

    is_wait = 1; ext_valid = 0;
    tick;
    chk("rw_stalled", stalled, 1);
    chk("rw_pc", pc, 1);
    nRst = 0;
    ext_valid = 1;
    #1;
    chk("rw_rst_stalled", stalled, 0);
    chk("rw_rst_ack", ext_ack, 0);
    tick;
    chk("rw_rst_ack2", ext_ack, 0);
    chk("rw_rst_pc", pc, 0);
    nRst = 1;
    clear_decode;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
